// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receiver and the upcoming transmitter:
//   - uart_state_t : frame FSM state encoding
//   - PAR_NONE / PAR_EVEN / PAR_ODD : parity mode constants
// Optional feature macro used by the consumers: UARTRX_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage : uart_pkg

// File: rtl/uartrx_param_if.sv
// -----------------------------------------------------------------------------
// uartrx_param_if
// Word delivery bus from the UART receiver to its consumer.
//   dout        : received word (LSB first on the line)
//   dout_valid  : word available
//   dout_ready  : consumer accepts the word when high together with dout_valid
//   frame_err   : stop bit(s) sampled low for the word in dout (qualified)
//   parity_err  : parity mismatch for the word in dout (qualified)
//   overrun_err : one-clk pulse, a word was dropped because dout was still full
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uartrx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output dout, dout_valid, frame_err, parity_err, overrun_err,
        input  dout_ready
    );

    modport slave (
        input  dout, dout_valid, frame_err, parity_err, overrun_err,
        output dout_ready
    );
endinterface : uartrx_param_if

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 so the
// line reads as idle while the design comes out of reset.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule : uart_sync2

// File: rtl/uartrx_param.sv
// -----------------------------------------------------------------------------
// uartrx_param
// Parametrised oversampling UART receiver with start-bit glitch rejection,
// frame/parity error flags and overrun detection.
// Parameters: DATA_BITS (5..8), OSR (even, 8..64), PARITY_MODE (uart_pkg
// PAR_*), STOP_BITS (1 or 2).
// Optional feature: define UARTRX_PARITY_EN to build the parity bit stage and
// parity_err; without it frames carry no parity bit and parity_err reads 0.
// Ports:
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   tick   : sample enable, OSR ticks per bit period
//   rx     : asynchronous serial input, idle high
//   busy   : high whenever the frame FSM is not idle
//   rx_if  : word delivery bus (master side)
// -----------------------------------------------------------------------------
module uartrx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OSR         = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           rx,
    output logic           busy,
    uartrx_param_if.master rx_if
);
    localparam int               CNT_W    = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OSR - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic             LAST_STP = 1'(STOP_BITS - 1);

`ifdef UARTRX_PARITY_EN
    localparam bit PAR_ACTIVE = (PARITY_MODE != PAR_NONE);
    localparam bit PAR_INVERT = (PARITY_MODE == PAR_ODD);
`else
    // Parity support compiled out: the mode setting has no effect.
    localparam bit PAR_ACTIVE = 1'b0 && (PARITY_MODE != PAR_NONE);
`endif

    logic                 rx_s;
    uart_state_t          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic                 armed_q;
    logic                 ferr_acc_q;
    logic                 perr_acc_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 dout_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic cnt_full;
    logic data_sample;
    logic commit;
    logic frame_now;
    logic accept;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign cnt_full    = (cnt_q == CNT_FULL);
    assign data_sample = tick && (state_q == ST_DATA) && cnt_full;
    // Final stop-bit sample: the word is complete on this tick.
    assign commit      = tick && (state_q == ST_STOP) && cnt_full && (stop_idx_q == LAST_STP);
    // Frame error including the stop sample being taken right now.
    assign frame_now   = ferr_acc_q | ~rx_s;
    assign accept      = dout_valid_q & rx_if.dout_ready;

    // Each data bit owns its flop and captures the line when its index is up;
    // every bit is rewritten each frame so no clearing is needed.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q[gi] <= 1'b0;
            end else if (data_sample && (bit_idx_q == 3'(gi))) begin
                shift_q[gi] <= rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            armed_q      <= 1'b0;
            ferr_acc_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        // A start needs a high-to-low transition; a line stuck
                        // low (break) never re-arms until it goes high again.
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                            armed_q <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= ST_IDLE;   // glitch, silently dropped
                            end else begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (cnt_full) begin
                            cnt_q <= '0;
                            if (bit_idx_q == LAST_BIT) begin
                                stop_idx_q <= 1'b0;
                                ferr_acc_q <= 1'b0;
                                state_q    <= PAR_ACTIVE ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`ifdef UARTRX_PARITY_EN
                    ST_PARITY: begin
                        if (cnt_full) begin
                            cnt_q      <= '0;
                            // Nonzero when data XOR parity bit disagrees with
                            // the selected sense (even: 0, odd: 1).
                            perr_acc_q <= rx_s ^ (^shift_q) ^ PAR_INVERT;
                            state_q    <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    ST_STOP: begin
                        if (cnt_full) begin
                            cnt_q      <= '0;
                            ferr_acc_q <= frame_now;
                            if (stop_idx_q == LAST_STP) begin
                                state_q <= ST_IDLE;
                                // A good stop level arms the next start in the
                                // very next tick for baud-mismatch tolerance.
                                armed_q <= rx_s;
                            end else begin
                                stop_idx_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end

            // Output register: a new word loads if the slot is free or being
            // emptied this clk; otherwise the new word is lost and flagged.
            if (commit) begin
                if (!dout_valid_q || accept) begin
                    dout_q       <= shift_q;
                    frame_err_q  <= frame_now;
                    parity_err_q <= perr_acc_q;
                    dout_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign busy              = (state_q != ST_IDLE);
    assign rx_if.dout        = dout_q;
    assign rx_if.dout_valid  = dout_valid_q;
    assign rx_if.frame_err   = frame_err_q;
`ifdef UARTRX_PARITY_EN
    assign rx_if.parity_err  = parity_err_q;
`else
    assign rx_if.parity_err  = 1'b0;
`endif
    assign rx_if.overrun_err = overrun_q;

endmodule : uartrx_param
